// File: rtl/sweep_acq_pkg.sv
// Shared types for the Sweep-ACQ sequencer and its neighbours.
// Holds the FSM state enum, the header tag default and the DAC code type.
package sweep_acq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WAIT_CFG,
    HDR0,
    HDR1,
    ACQ,
    DRAIN,
    NEXT,
    DONE
  } sweepState_t;

  typedef logic [9:0] dacCode_t;

  localparam logic [15:0] SWEEP_HDR_TAG = 16'h5354;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sweep_acq_pkt_counter.sv
// Word/package counter for one DAC step of the sweep.
// Ports: clr/inc control, maxPkg target, termCnt = this inc completes the step.
module sweep_acq_pkt_counter
  import sweep_acq_pkg::*;
#(
  parameter int PACKAGE_WORDS = 256
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  input  logic [15:0] maxPkg,
  output logic        termCnt
);

  localparam int WW = cntWidth(PACKAGE_WORDS);

  logic [WW-1:0] wordCnt;
  logic [15:0]   pkgCnt;
  logic          wrap;

  assign wrap = (wordCnt == WW'(PACKAGE_WORDS - 1));

  // Fires on the word that closes the last package of the step.
  assign termCnt = inc && wrap &&
                   ((pkgCnt + 16'd1) == maxPkg);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wordCnt <= '0;
      pkgCnt  <= '0;
    end else if (clr) begin
      wordCnt <= '0;
      pkgCnt  <= '0;
    end else if (inc) begin
      if (wrap) begin
        wordCnt <= '0;
        pkgCnt  <= pkgCnt + 16'd1;
      end else begin
        wordCnt <= wordCnt + WW'(1);
      end
    end
  end

endmodule

// File: rtl/sweep_acq_control.sv
// Sweep-ACQ sequencer: steps DAC0, loads slow control, acquires, tags data.
// Ports: sweep config in, SC load/config handshake, acq enable, data stream.
module sweep_acq_control
  import sweep_acq_pkg::*;
#(
  parameter int          PACKAGE_WORDS = 256,
  parameter int          DRAIN_CYCLES  = 64,
  parameter logic [15:0] HEADER_TAG    = SWEEP_HDR_TAG
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        SweepStart,
  input  logic [9:0]  StartDac,
  input  logic [9:0]  EndDac,
  input  logic [15:0] MaxPackageNumber,
  output logic [9:0]  OutDac0,
  output logic        LoadScParameter,
  input  logic        MicrorocConfigDone,
  output logic        AcqStartStop,
  input  logic [15:0] ParallelData,
  input  logic        ParallelData_en,
  input  logic        UsbDataFifoFull,
  output logic [15:0] SweepAcqData,
  output logic        SweepAcqData_en,
  output logic        Overflow,
  output logic        SweepTestDone,
  input  logic        DataTransmitDone
);

  localparam int DW = cntWidth(DRAIN_CYCLES);

  sweepState_t state;
  sweepState_t nextState;

  dacCode_t    dac;
  dacCode_t    endDac;
  logic [15:0] maxPkg;
  logic        down;
  logic        startQ;
  logic        startPulse;
  logic [DW-1:0] drainCnt;
  logic [15:0] dataQ;
  logic        dataEnQ;
  logic        ovfQ;

  logic abort;
  logic emitTag;
  logic emitDac;
  logic fwd;
  logic latchStart;
  logic stepDac;
  logic cntClr;
  logic cntInc;
  logic termCnt;

  sweep_acq_pkt_counter #(
    .PACKAGE_WORDS(PACKAGE_WORDS)
  ) uCnt (
    .Clk    (Clk),
    .reset_n(reset_n),
    .clr    (cntClr),
    .inc    (cntInc),
    .maxPkg (maxPkg),
    .termCnt(termCnt)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Header words are registered on the transition out of the
  // waiting state, so a word lands the cycle after its trigger.
  always_comb begin
    nextState  = state;
    emitTag    = 1'b0;
    emitDac    = 1'b0;
    fwd        = 1'b0;
    latchStart = 1'b0;
    stepDac    = 1'b0;
    cntClr     = 1'b0;
    cntInc     = 1'b0;
    abort      = !SweepStart &&
                 (state != IDLE) &&
                 (state != DONE);
    if (abort) begin
      nextState = IDLE;
      cntClr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cntClr = 1'b1;
          if (startPulse) begin
            latchStart = 1'b1;
            nextState  = LOAD;
          end
        end
        LOAD: nextState = WAIT_CFG;
        WAIT_CFG: begin
          if (MicrorocConfigDone) begin
            if (!UsbDataFifoFull) begin
              emitTag   = 1'b1;
              nextState = HDR1;
            end else begin
              nextState = HDR0;
            end
          end
        end
        HDR0: begin
          if (!UsbDataFifoFull) begin
            emitTag   = 1'b1;
            nextState = HDR1;
          end
        end
        HDR1: begin
          if (!UsbDataFifoFull) begin
            emitDac   = 1'b1;
            nextState = (maxPkg == 16'd0) ? NEXT : ACQ;
          end
        end
        ACQ: begin
          fwd    = 1'b1;
          cntInc = ParallelData_en;
          if (termCnt) nextState = DRAIN;
        end
        DRAIN: begin
          fwd = 1'b1;
          if (drainCnt == DW'(DRAIN_CYCLES - 1))
            nextState = NEXT;
        end
        NEXT: begin
          cntClr = 1'b1;
          if (dac == endDac) begin
            nextState = DONE;
          end else begin
            stepDac   = 1'b1;
            nextState = LOAD;
          end
        end
        DONE: begin
          if (DataTransmitDone) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      dac        <= '0;
      endDac     <= '0;
      maxPkg     <= '0;
      down       <= 1'b0;
      startQ     <= 1'b0;
      startPulse <= 1'b0;
      drainCnt   <= '0;
      dataQ      <= '0;
      dataEnQ    <= 1'b0;
      ovfQ       <= 1'b0;
    end else begin
      startQ     <= SweepStart;
      startPulse <= SweepStart & ~startQ;
      dataEnQ    <= 1'b0;
      if (state == DRAIN) drainCnt <= drainCnt + DW'(1);
      else                drainCnt <= '0;
      if (latchStart) begin
        dac    <= StartDac;
        endDac <= EndDac;
        maxPkg <= MaxPackageNumber;
        down   <= (StartDac > EndDac);
        ovfQ   <= 1'b0;
      end
      // NEXT only steps when dac != endDac, so no wrap is possible.
      if (stepDac) begin
        if (down) dac <= dac - 10'd1;
        else      dac <= dac + 10'd1;
      end
      if (emitTag) begin
        dataQ   <= HEADER_TAG;
        dataEnQ <= 1'b1;
      end else if (emitDac) begin
        dataQ   <= {6'b0, dac};
        dataEnQ <= 1'b1;
      end else if (fwd && ParallelData_en) begin
        if (UsbDataFifoFull) begin
          ovfQ <= 1'b1;
        end else begin
          dataQ   <= ParallelData;
          dataEnQ <= 1'b1;
        end
      end
    end
  end

  assign OutDac0         = dac;
  assign LoadScParameter = (state == LOAD);
  assign AcqStartStop    = (state == ACQ);
  assign SweepTestDone   = (state == DONE);
  assign SweepAcqData    = dataQ;
  assign SweepAcqData_en = dataEnQ;
  assign Overflow        = ovfQ;

endmodule

// File: tb/tb_sweep_acq_control.sv
// Self-checking bench for sweep_acq_control.
// Table sweeps, hand corner cases and random sweeps vs a stream model.
module tb_sweep_acq_control;

  localparam int PW = 4;
  localparam int DC = 4;
  localparam logic [15:0] TAG = 16'h5354;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SweepStart = 1'b0;
  logic [9:0]  StartDac = '0;
  logic [9:0]  EndDac = '0;
  logic [15:0] MaxPackageNumber = '0;
  logic        MicrorocConfigDone = 1'b0;
  logic [15:0] ParallelData = '0;
  logic        ParallelData_en = 1'b0;
  logic        UsbDataFifoFull = 1'b0;
  logic        DataTransmitDone = 1'b0;
  logic [9:0]  OutDac0;
  logic        LoadScParameter;
  logic        AcqStartStop;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        Overflow;
  logic        SweepTestDone;

  sweep_acq_control #(
    .PACKAGE_WORDS(PW),
    .DRAIN_CYCLES (DC)
  ) dut (
    .Clk               (Clk),
    .reset_n           (reset_n),
    .SweepStart        (SweepStart),
    .StartDac          (StartDac),
    .EndDac            (EndDac),
    .MaxPackageNumber  (MaxPackageNumber),
    .OutDac0           (OutDac0),
    .LoadScParameter   (LoadScParameter),
    .MicrorocConfigDone(MicrorocConfigDone),
    .AcqStartStop      (AcqStartStop),
    .ParallelData      (ParallelData),
    .ParallelData_en   (ParallelData_en),
    .UsbDataFifoFull   (UsbDataFifoFull),
    .SweepAcqData      (SweepAcqData),
    .SweepAcqData_en   (SweepAcqData_en),
    .Overflow          (Overflow),
    .SweepTestDone     (SweepTestDone),
    .DataTransmitDone  (DataTransmitDone)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int rLoads;
  int rWords;
  int rAcq;

  typedef struct {
    logic [9:0]  s;
    logic [9:0]  e;
    logic [15:0] m;
    int          loads;
    int          words;
    int          acq;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  // Drives one whole sweep like the chip/host would and scores
  // the output stream against headers + undropped data words.
  task automatic runSweep(input logic [9:0] s,
                          input logic [9:0] e,
                          input logic [15:0] m,
                          input int fullPct);
    logic [9:0]  seq[$];
    logic [15:0] expQ[$];
    logic [15:0] gotQ[$];
    logic [9:0]  d;
    int sent = 0;
    int target;
    int dropped = 0;
    int cfgWait = -1;
    int cyc = 0;
    bit lastPend = 1'b0;
    bit done = 1'b0;
    d = s;
    while (1) begin
      seq.push_back(d);
      if (d == e) break;
      d = (s > e) ? d - 10'd1 : d + 10'd1;
    end
    target = int'(m) * PW;
    rLoads = 0;
    rAcq = 0;
    StartDac = s;
    EndDac = e;
    MaxPackageNumber = m;
    SweepStart = 1'b1;
    while (!done && cyc < 3000) begin
      tick;
      cyc++;
      if (SweepAcqData_en) gotQ.push_back(SweepAcqData);
      if (AcqStartStop) rAcq++;
      if (lastPend) begin
        chk("acq_fall", {31'b0, AcqStartStop}, 0);
        lastPend = 1'b0;
      end
      if (LoadScParameter) begin
        if (rLoads < seq.size()) begin
          chk("outdac", {22'b0, OutDac0},
              {22'b0, seq[rLoads]});
          expQ.push_back(TAG);
          expQ.push_back({6'b0, seq[rLoads]});
        end else begin
          chk("load_count", rLoads + 1, seq.size());
        end
        rLoads++;
        sent = 0;
        cfgWait = $urandom_range(1, 3);
      end
      if (SweepTestDone) done = 1'b1;
      MicrorocConfigDone = 1'b0;
      if (cfgWait == 0) begin
        MicrorocConfigDone = 1'b1;
        cfgWait = -1;
      end else if (cfgWait > 0) begin
        cfgWait--;
      end
      UsbDataFifoFull = ($urandom_range(0, 99) < fullPct);
      ParallelData_en = 1'b0;
      if (AcqStartStop && sent < target &&
          $urandom_range(0, 3) != 0) begin
        ParallelData_en = 1'b1;
        ParallelData = 16'($urandom);
        sent++;
        if (UsbDataFifoFull) dropped++;
        else expQ.push_back(ParallelData);
        if (sent == target) lastPend = 1'b1;
      end
    end
    ParallelData_en = 1'b0;
    UsbDataFifoFull = 1'b0;
    MicrorocConfigDone = 1'b0;
    chk("done_reached", {31'b0, done}, 1);
    chk("loads", rLoads, seq.size());
    rWords = gotQ.size();
    chk("stream_len", gotQ.size(), expQ.size());
    if (gotQ.size() == expQ.size()) begin
      foreach (gotQ[i])
        chk("stream_word", {16'b0, gotQ[i]},
            {16'b0, expQ[i]});
    end
    chk("overflow", {31'b0, Overflow},
        (dropped > 0) ? 1 : 0);
    DataTransmitDone = 1'b1;
    tick;
    DataTransmitDone = 1'b0;
    chk("done_fall", {31'b0, SweepTestDone}, 0);
    SweepStart = 1'b0;
    tick;
  endtask

  task automatic chkZero(input string nm);
    chk({nm, "_dac"}, {22'b0, OutDac0}, 0);
    chk({nm, "_load"}, {31'b0, LoadScParameter}, 0);
    chk({nm, "_acq"}, {31'b0, AcqStartStop}, 0);
    chk({nm, "_data"}, {16'b0, SweepAcqData}, 0);
    chk({nm, "_en"}, {31'b0, SweepAcqData_en}, 0);
    chk({nm, "_ovf"}, {31'b0, Overflow}, 0);
    chk({nm, "_done"}, {31'b0, SweepTestDone}, 0);
  endtask

  initial begin
    logic [15:0] got[$];
    int hdrSeen;
    int quiet;
    int waitCyc;

    vt[0] = '{10'd100, 10'd102, 16'd2, 3, 30, 1};
    vt[1] = '{10'd5, 10'd3, 16'd1, 3, 18, 1};
    vt[2] = '{10'h3FF, 10'h3FF, 16'd0, 1, 2, 0};
    vt[3] = '{10'd0, 10'd0, 16'd3, 1, 14, 1};

    repeat (2) tick;
    chkZero("rst");
    reset_n = 1'b1;
    tick;

    // Start timing, header held off by a full FIFO, data drops.
    StartDac = 10'd7;
    EndDac = 10'd7;
    MaxPackageNumber = 16'd1;
    SweepStart = 1'b1;
    tick;
    chk("load_early", {31'b0, LoadScParameter}, 0);
    tick;
    chk("load_2cyc", {31'b0, LoadScParameter}, 1);
    chk("load_dac", {22'b0, OutDac0}, 7);
    UsbDataFifoFull = 1'b1;
    tick;
    MicrorocConfigDone = 1'b1;
    tick;
    MicrorocConfigDone = 1'b0;
    hdrSeen = 0;
    repeat (9) begin
      tick;
      hdrSeen += int'(SweepAcqData_en);
    end
    UsbDataFifoFull = 1'b0;
    tick;
    chk("hdr_held", hdrSeen, 0);
    chk("hdr0_en", {31'b0, SweepAcqData_en}, 1);
    chk("hdr0", {16'b0, SweepAcqData}, TAG);
    tick;
    chk("hdr1", {16'b0, SweepAcqData}, 7);
    chk("acq_rise", {31'b0, AcqStartStop}, 1);
    for (int i = 0; i < 4; i++) begin
      ParallelData = 16'hA000 + 16'(i);
      ParallelData_en = 1'b1;
      UsbDataFifoFull = (i == 1 || i == 2);
      tick;
      if (SweepAcqData_en) got.push_back(SweepAcqData);
    end
    ParallelData_en = 1'b0;
    UsbDataFifoFull = 1'b0;
    tick;
    if (SweepAcqData_en) got.push_back(SweepAcqData);
    chk("full_acq_fall", {31'b0, AcqStartStop}, 0);
    chk("full_ovf", {31'b0, Overflow}, 1);
    chk("full_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("full_w0", {16'b0, got[0]}, 32'hA000);
      chk("full_w1", {16'b0, got[1]}, 32'hA003);
    end
    waitCyc = 0;
    while (!SweepTestDone && waitCyc < 40) begin
      tick;
      waitCyc++;
    end
    chk("full_done", {31'b0, SweepTestDone}, 1);
    DataTransmitDone = 1'b1;
    tick;
    DataTransmitDone = 1'b0;
    chk("full_done_fall", {31'b0, SweepTestDone}, 0);
    SweepStart = 1'b0;
    tick;

    for (int v = 0; v < 4; v++) begin
      runSweep(vt[v].s, vt[v].e, vt[v].m, 0);
      chk("tbl_loads", rLoads, vt[v].loads);
      chk("tbl_words", rWords, vt[v].words);
      chk("tbl_acq", (rAcq > 0) ? 1 : 0, vt[v].acq);
    end

    // Abort mid-ACQ, then restart from StartDac.
    StartDac = 10'd10;
    EndDac = 10'd12;
    MaxPackageNumber = 16'd2;
    SweepStart = 1'b1;
    tick;
    tick;
    tick;
    MicrorocConfigDone = 1'b1;
    tick;
    MicrorocConfigDone = 1'b0;
    chk("hdr_lat_en", {31'b0, SweepAcqData_en}, 1);
    chk("hdr_lat", {16'b0, SweepAcqData}, TAG);
    tick;
    chk("ab_acq", {31'b0, AcqStartStop}, 1);
    ParallelData_en = 1'b1;
    UsbDataFifoFull = 1'b1;
    tick;
    ParallelData_en = 1'b0;
    UsbDataFifoFull = 1'b0;
    chk("ab_ovf", {31'b0, Overflow}, 1);
    SweepStart = 1'b0;
    tick;
    chk("ab_acq_off", {31'b0, AcqStartStop}, 0);
    quiet = 0;
    repeat (5) begin
      tick;
      quiet += int'(SweepTestDone) +
               int'(LoadScParameter) +
               int'(AcqStartStop);
    end
    chk("ab_quiet", quiet, 0);
    SweepStart = 1'b1;
    tick;
    tick;
    chk("re_load", {31'b0, LoadScParameter}, 1);
    chk("re_dac", {22'b0, OutDac0}, 10);
    chk("re_ovf", {31'b0, Overflow}, 0);
    SweepStart = 1'b0;
    repeat (2) tick;

    // Reset in WAIT_CFG, then a stale config-done.
    StartDac = 10'd20;
    EndDac = 10'd21;
    MaxPackageNumber = 16'd1;
    SweepStart = 1'b1;
    tick;
    tick;
    tick;
    #2;
    reset_n = 1'b0;
    SweepStart = 1'b0;
    #1;
    chkZero("arst");
    tick;
    reset_n = 1'b1;
    tick;
    MicrorocConfigDone = 1'b1;
    tick;
    MicrorocConfigDone = 1'b0;
    quiet = 0;
    repeat (4) begin
      tick;
      quiet += int'(SweepAcqData_en) +
               int'(LoadScParameter) +
               int'(AcqStartStop);
    end
    chk("late_cfg", quiet, 0);

    for (int r = 0; r < 6; r++) begin
      int s0;
      int span;
      int e0;
      s0 = $urandom_range(0, 1023);
      span = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        e0 = (s0 + span > 1023) ? 1023 : s0 + span;
      else
        e0 = (s0 - span < 0) ? 0 : s0 - span;
      runSweep(10'(s0), 10'(e0),
               16'($urandom_range(0, 3)),
               $urandom_range(0, 40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
